// File: rtl/mdu_ctrl_if.sv
// EX-stage request bundle and HI/LO result view for the multiply/divide unit.
// The master is the pipeline side, the slave is mdu_ctrl.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        ID_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, A, B, ID_is_md,
        input  busy, md_stall, HI, LO
    );

    modport slave (
        input  start, op, A, B, ID_is_md,
        output busy, md_stall, HI, LO
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO.
// Fixed-latency countdown; results are written back on the final busy edge.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   md
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_arith;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_sgn_mul;
    logic        w_sgn_div;
    logic [63:0] w_ax;
    logic [63:0] w_bx;
    logic [63:0] w_prod;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_dvs_safe;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic        w_dvs_zero;

    assign w_arith = md.start
                   & (md.op >= OP_MULT)
                   & (md.op <= OP_DIVU);

    assign w_is_mul  = (r_op == OP_MULT) | (r_op == OP_MULTU);
    assign w_is_div  = (r_op == OP_DIV)  | (r_op == OP_DIVU);
    assign w_sgn_mul = (r_op == OP_MULT);
    assign w_sgn_div = (r_op == OP_DIV);

    // Low 64 bits of the extended product equal the signed/unsigned product.
    assign w_ax   = {{32{w_sgn_mul & r_a[31]}}, r_a};
    assign w_bx   = {{32{w_sgn_mul & r_b[31]}}, r_b};
    assign w_prod = w_ax * w_bx;

    // Signed divide via magnitudes; 0x80000000 / -1 wraps to 0x80000000.
    assign w_dvd = (w_sgn_div & r_a[31]) ? (~r_a + 32'd1) : r_a;
    assign w_dvs = (w_sgn_div & r_b[31]) ? (~r_b + 32'd1) : r_b;
    assign w_dvs_zero = (r_b == 32'd0);
    assign w_dvs_safe = w_dvs_zero ? 32'd1 : w_dvs;
    assign w_uq = w_dvd / w_dvs_safe;
    assign w_ur = w_dvd % w_dvs_safe;
    assign w_q  = (w_sgn_div & (r_a[31] ^ r_b[31]))
                ? (~w_uq + 32'd1) : w_uq;
    assign w_r  = (w_sgn_div & r_a[31])
                ? (~w_ur + 32'd1) : w_ur;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    unique case (1'b1)
                        w_arith: begin
                            r_op    <= md.op;
                            r_a     <= md.A;
                            r_b     <= md.B;
                            r_state <= BUSY;
                            r_cnt   <= (md.op <= OP_MULTU)
                                     ? 4'(MULT_CYCLES)
                                     : 4'(DIV_CYCLES);
                        end
                        (md.start & (md.op == OP_MTHI)): r_hi <= md.A;
                        (md.start & (md.op == OP_MTLO)): r_lo <= md.A;
                        default: ;
                    endcase
                end
                BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                        unique case (1'b1)
                            w_is_mul: begin
                                r_hi <= w_prod[63:32];
                                r_lo <= w_prod[31:0];
                            end
                            (w_is_div & ~w_dvs_zero): begin
                                r_hi <= w_r;
                                r_lo <= w_q;
                            end
                            default: ;
                        endcase
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign md.busy     = (r_state == BUSY);
    assign md.md_stall = md.ID_is_md & (md.busy | w_arith);
    assign md.HI       = r_hi;
    assign md.LO       = r_lo;
endmodule
